// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: exception codes, register addresses, field positions
// and the fixed exception-priority encoder.
package cp0_pkg;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // Address is {rd[4:0], sel[2:0]}; every implemented register uses sel 0.
  localparam logic [7:0] ADDR_BADVADDR = 8'h40;
  localparam logic [7:0] ADDR_COUNT    = 8'h48;
  localparam logic [7:0] ADDR_COMPARE  = 8'h58;
  localparam logic [7:0] ADDR_STATUS   = 8'h60;
  localparam logic [7:0] ADDR_CAUSE    = 8'h68;
  localparam logic [7:0] ADDR_EPC      = 8'h70;

  localparam int ST_IE     = 0;
  localparam int ST_EXL    = 1;
  localparam int ST_IM_LO  = 8;
  localparam int CA_EXC_LO = 2;
  localparam int CA_IP_LO  = 8;
  localparam int CA_TI     = 30;
  localparam int CA_BD     = 31;

  localparam logic [31:0] STATUS_RESET = 32'h0040_0000;
  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;

  // exc_vec = {adel_if, ri, ov, sys, bp, adel, ades}; interrupt beats all.
  function automatic logic [4:0] exc_code(input logic irq, input logic [6:0] v);
    if (irq)       return EXC_INT;
    else if (v[6]) return EXC_ADEL;
    else if (v[5]) return EXC_RI;
    else if (v[4]) return EXC_OV;
    else if (v[3]) return EXC_SYS;
    else if (v[2]) return EXC_BP;
    else if (v[1]) return EXC_ADEL;
    else           return EXC_ADES;
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer with a Count prescaler and a sticky timer interrupt (TI).
module cp0_timer
  import cp0_pkg::*;
#(
  parameter int COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        count_wen,
  input  logic        compare_wen,
  input  logic [31:0] wdata,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        ti_o
);

  localparam logic [3:0] PRESC_MAX = 4'(COUNT_DIV - 1);

  logic [3:0]  presc_q, presc_d;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        ti_q, ti_d;

  always_comb begin
    presc_d   = presc_q;
    count_d   = count_q;
    compare_d = compare_q;
    ti_d      = ti_q | (count_q == compare_q);
    if (presc_q == PRESC_MAX) begin
      presc_d = 4'd0;
      count_d = count_q + 32'd1;
    end else begin
      presc_d = presc_q + 4'd1;
    end
    // Software writes take precedence over the free-running update.
    if (count_wen) begin
      count_d = wdata;
      presc_d = 4'd0;
    end
    if (compare_wen) begin
      compare_d = wdata;
      ti_d      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      presc_q   <= 4'd0;
      count_q   <= 32'd0;
      compare_q <= 32'd0;
      ti_q      <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      ti_q      <= ti_d;
    end
  end

  assign count_o   = count_q;
  assign compare_o = compare_q;
  assign ti_o      = ti_q;

endmodule

// File: rtl/cp0_unit.sv
// Coprocessor 0: Status/Cause/EPC/BadVAddr plus timer; takes precise traps
// at commit, services ERET and drives the pipeline flush/redirect.
module cp0_unit
  import cp0_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
  parameter int          HW_INT_NUM = 6,
  parameter int          COUNT_DIV  = 2,
  parameter int          TIMER_IP   = 7
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  commit_valid,
  input  logic [31:0]           commit_pc,
  input  logic                  commit_bd,
  input  logic [6:0]            exc_vec,
  input  logic [31:0]           dm_addr,
  input  logic                  eret,
  input  logic                  mtc0_wen,
  input  logic [7:0]            cp0_addr,
  input  logic [31:0]           mtc0_wdata,
  output logic [31:0]           mfc0_rdata,
  input  logic [HW_INT_NUM-1:0] ext_int,
  output logic                  flush,
  output logic [31:0]           flush_pc,
  output logic                  int_pending,
  output logic [31:0]           status_o,
  output logic [31:0]           cause_o,
  output logic [31:0]           epc_o
);

  logic [31:0]           status_q, status_d;
  logic [31:0]           epc_q, epc_d;
  logic [31:0]           badvaddr_q, badvaddr_d;
  logic [4:0]            exccode_q, exccode_d;
  logic                  bd_q, bd_d;
  logic [1:0]            ip_sw_q, ip_sw_d;
  logic [HW_INT_NUM-1:0] ip_hw_q;

  logic [31:0] count, compare;
  logic        ti;
  logic [7:0]  ip;
  logic        take, eret_fire, mtc0_fire, exl;

  always_comb begin
    ip              = 8'd0;
    ip[1:0]         = ip_sw_q;
    ip[2 +: HW_INT_NUM] = ip_hw_q;
    ip[TIMER_IP]    = ip[TIMER_IP] | ti;
  end

  assign exl         = status_q[ST_EXL];
  assign int_pending = status_q[ST_IE] & ~exl & |(ip & status_q[ST_IM_LO +: 8]);
  assign take        = commit_valid & (int_pending | |exc_vec);
  assign eret_fire   = commit_valid & eret & ~take;
  assign mtc0_fire   = commit_valid & mtc0_wen & ~take;

  assign flush    = take | eret_fire;
  assign flush_pc = take ? EXC_VECTOR : epc_q;

  always_comb begin
    status_d   = status_q;
    epc_d      = epc_q;
    badvaddr_d = badvaddr_q;
    exccode_d  = exccode_q;
    bd_d       = bd_q;
    ip_sw_d    = ip_sw_q;
    if (take) begin
      exccode_d        = exc_code(int_pending, exc_vec);
      status_d[ST_EXL] = 1'b1;
      if (!exl) begin
        epc_d = commit_bd ? commit_pc - 32'd4 : commit_pc;
        bd_d  = commit_bd;
      end
      // ExcCode 4 is shared by adel_if and adel, so decode the source here.
      if (!int_pending) begin
        if (exc_vec[6])
          badvaddr_d = commit_pc;
        else if (exc_vec[5:2] == 4'd0)
          badvaddr_d = dm_addr;
      end
    end else begin
      if (mtc0_fire) begin
        case (cp0_addr)
          ADDR_STATUS: status_d = (status_q & ~STATUS_WMASK) | (mtc0_wdata & STATUS_WMASK);
          ADDR_CAUSE:  ip_sw_d  = mtc0_wdata[9:8];
          ADDR_EPC:    epc_d    = mtc0_wdata;
          default:     ;
        endcase
      end
      if (eret_fire) status_d[ST_EXL] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      status_q   <= STATUS_RESET;
      epc_q      <= 32'd0;
      badvaddr_q <= 32'd0;
      exccode_q  <= 5'd0;
      bd_q       <= 1'b0;
      ip_sw_q    <= 2'd0;
      ip_hw_q    <= '0;
    end else begin
      status_q   <= status_d;
      epc_q      <= epc_d;
      badvaddr_q <= badvaddr_d;
      exccode_q  <= exccode_d;
      bd_q       <= bd_d;
      ip_sw_q    <= ip_sw_d;
      ip_hw_q    <= ext_int;
    end
  end

  cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
    .clk        (clk),
    .resetn     (resetn),
    .count_wen  (mtc0_fire && cp0_addr == ADDR_COUNT),
    .compare_wen(mtc0_fire && cp0_addr == ADDR_COMPARE),
    .wdata      (mtc0_wdata),
    .count_o    (count),
    .compare_o  (compare),
    .ti_o       (ti)
  );

  assign status_o = status_q;
  assign cause_o  = {bd_q, ti, 14'd0, ip, 1'b0, exccode_q, 2'b00};
  assign epc_o    = epc_q;

  always_comb begin
    case (cp0_addr)
      ADDR_BADVADDR: mfc0_rdata = badvaddr_q;
      ADDR_COUNT:    mfc0_rdata = count;
      ADDR_COMPARE:  mfc0_rdata = compare;
      ADDR_STATUS:   mfc0_rdata = status_q;
      ADDR_CAUSE:    mfc0_rdata = cause_o;
      ADDR_EPC:      mfc0_rdata = epc_q;
      default:       mfc0_rdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_cp0_unit.sv
// Directed bench for cp0_unit: traps, priority, ERET, timer and interrupts.
module tb_cp0_unit;
  import cp0_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        commit_valid;
  logic [31:0] commit_pc;
  logic        commit_bd;
  logic [6:0]  exc_vec;
  logic [31:0] dm_addr;
  logic        eret;
  logic        mtc0_wen;
  logic [7:0]  cp0_addr;
  logic [31:0] mtc0_wdata;
  logic [31:0] mfc0_rdata;
  logic [5:0]  ext_int;
  logic        flush;
  logic [31:0] flush_pc;
  logic        int_pending;
  logic [31:0] status_o, cause_o, epc_o;

  int checks = 0;
  int errors = 0;
  int n;

  cp0_unit dut (
    .clk(clk), .resetn(resetn), .commit_valid(commit_valid), .commit_pc(commit_pc),
    .commit_bd(commit_bd), .exc_vec(exc_vec), .dm_addr(dm_addr), .eret(eret),
    .mtc0_wen(mtc0_wen), .cp0_addr(cp0_addr), .mtc0_wdata(mtc0_wdata),
    .mfc0_rdata(mfc0_rdata), .ext_int(ext_int), .flush(flush), .flush_pc(flush_pc),
    .int_pending(int_pending), .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    commit_valid = 1'b0; commit_pc = 32'd0; commit_bd = 1'b0; exc_vec = 7'd0;
    dm_addr = 32'd0; eret = 1'b0; mtc0_wen = 1'b0; mtc0_wdata = 32'd0;
  endtask

  task automatic mtc0(input logic [7:0] a, input logic [31:0] d);
    commit_valid = 1'b1; mtc0_wen = 1'b1; cp0_addr = a; mtc0_wdata = d;
    tick();
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; ext_int = 6'd0; cp0_addr = 8'd0; idle();
    tick(); tick();
    chk("rst_status", status_o, 32'h0040_0000);
    chk("rst_cause", cause_o, 32'd0);
    chk("rst_epc", epc_o, 32'd0);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    resetn = 1'b1;

    // Timer: Compare=5, Count=0, IM7+IE; TI appears 11 edges after Count write.
    mtc0(ADDR_COMPARE, 32'd5);
    mtc0(ADDR_COUNT, 32'd0);
    chk("ti_clear_after_cmp", {31'd0, cause_o[CA_TI]}, 32'd0);
    mtc0(ADDR_STATUS, 32'h0000_8001);
    n = 1;
    while (!cause_o[CA_TI] && n < 40) begin
      tick();
      n++;
    end
    chk("ti_latency", n, 32'd11);
    cp0_addr = ADDR_COUNT; #1;
    chk("count_at_ti", mfc0_rdata, 32'd5);
    chk("ti_pending", {31'd0, int_pending}, 32'd1);
    chk("ti_no_flush", {31'd0, flush}, 32'd0);
    commit_valid = 1'b1; commit_pc = 32'h8000_1000; #1;
    chk("ti_trap_flush", {31'd0, flush}, 32'd1);
    tick(); idle();
    chk("ti_trap_epc", epc_o, 32'h8000_1000);
    chk("ti_trap_code", {27'd0, cause_o[6:2]}, 32'd0);
    chk("ti_trap_exl", {31'd0, status_o[ST_EXL]}, 32'd1);
    mtc0(ADDR_COMPARE, 32'h7FFF_FFFF);
    chk("ti_cleared", {31'd0, cause_o[CA_TI]}, 32'd0);
    mtc0(ADDR_STATUS, 32'd0);
    chk("status_clear", status_o, 32'h0040_0000);

    // Bubble with exception flags never traps.
    exc_vec = 7'b0001000; #1;
    chk("bubble_no_flush", {31'd0, flush}, 32'd0);
    idle();

    // Syscall.
    commit_valid = 1'b1; commit_pc = 32'hBFC0_0100; exc_vec = 7'b0001000; #1;
    chk("sys_flush", {31'd0, flush}, 32'd1);
    chk("sys_flush_pc", flush_pc, 32'hBFC0_0380);
    tick(); idle();
    chk("sys_epc", epc_o, 32'hBFC0_0100);
    chk("sys_code", {27'd0, cause_o[6:2]}, 32'd8);
    chk("sys_exl", {31'd0, status_o[ST_EXL]}, 32'd1);
    chk("sys_bd", {31'd0, cause_o[CA_BD]}, 32'd0);
    mtc0(ADDR_STATUS, 32'd0);

    // adel in a delay slot.
    commit_valid = 1'b1; commit_pc = 32'h8000_0010; commit_bd = 1'b1;
    exc_vec = 7'b0000010; dm_addr = 32'h8000_0003;
    tick(); idle();
    cp0_addr = ADDR_BADVADDR; #1;
    chk("adel_epc", epc_o, 32'h8000_000C);
    chk("adel_bd", {31'd0, cause_o[CA_BD]}, 32'd1);
    chk("adel_code", {27'd0, cause_o[6:2]}, 32'd4);
    chk("adel_badva", mfc0_rdata, 32'h8000_0003);

    // ri+ov with EXL=1, plus a suppressed MTC0 EPC in the same commit.
    commit_valid = 1'b1; commit_pc = 32'h1234_5678; exc_vec = 7'b0110000;
    mtc0_wen = 1'b1; cp0_addr = ADDR_EPC; mtc0_wdata = 32'hDEAD_0000; #1;
    chk("nest_flush_pc", flush_pc, 32'hBFC0_0380);
    tick(); idle();
    chk("nest_code", {27'd0, cause_o[6:2]}, 32'd10);
    chk("nest_epc", epc_o, 32'h8000_000C);
    cp0_addr = ADDR_BADVADDR; #1;
    chk("nest_badva", mfc0_rdata, 32'h8000_0003);

    // ERET with a same-cycle MTC0 EPC: redirect uses the old EPC.
    mtc0(ADDR_EPC, 32'hBFC0_0200);
    chk("epc_write", epc_o, 32'hBFC0_0200);
    commit_valid = 1'b1; eret = 1'b1; mtc0_wen = 1'b1; cp0_addr = ADDR_EPC;
    mtc0_wdata = 32'h1111_1111; #1;
    chk("eret_flush", {31'd0, flush}, 32'd1);
    chk("eret_flush_pc", flush_pc, 32'hBFC0_0200);
    tick(); idle();
    chk("eret_exl", {31'd0, status_o[ST_EXL]}, 32'd0);
    chk("eret_epc_wr", epc_o, 32'h1111_1111);

    // External interrupt line 1 -> IP[3]; held pending until a commit.
    ext_int = 6'b000010;
    mtc0(ADDR_STATUS, 32'h0000_0801);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("irq_pending", {30'd0, int_pending, flush}, 32'd2);
    end
    commit_valid = 1'b1; commit_pc = 32'h8000_2000; exc_vec = 7'b0001000; #1;
    chk("irq_flush_pc", flush_pc, 32'hBFC0_0380);
    tick(); idle();
    chk("irq_epc", epc_o, 32'h8000_2000);
    chk("irq_code", {27'd0, cause_o[6:2]}, 32'd0);
    chk("irq_ip3", {31'd0, cause_o[CA_IP_LO+3]}, 32'd1);

    // Reset in the middle of activity.
    resetn = 1'b0; commit_valid = 1'b1; mtc0_wen = 1'b1; cp0_addr = ADDR_EPC;
    mtc0_wdata = 32'h5555_5555;
    tick(); idle();
    chk("rst2_status", status_o, 32'h0040_0000);
    chk("rst2_cause", cause_o, 32'd0);
    chk("rst2_epc", epc_o, 32'd0);
    chk("rst2_pending", {31'd0, int_pending}, 32'd0);
    resetn = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cp0_unit.md
Name: cp0_unit

Overview:
Parametrised coprocessor-0 block for the MIPS pipeline, split out of the write-back stage and generalised. Holds Status, Cause, EPC, BadVAddr, Count and Compare. Takes a precise exception or interrupt at the commit point, services ERET, and drives the pipeline flush/redirect. Adds a configurable interrupt-line count, a Count prescaler, a timer interrupt routed to a selectable IP bit, and a fixed exception priority.

Parameters:
EXC_VECTOR, 32'hBFC00380, exception entry address
HW_INT_NUM, 6, number of external interrupt lines; 1..6, mapped to Cause.IP[2+HW_INT_NUM-1:2]
COUNT_DIV, 2, Count increments once every COUNT_DIV cycles; 1..16
TIMER_IP, 7, Cause.IP index OR-ed with the timer interrupt (TI); 2..7

Ports:
clk  in  1  clock
resetn  in  1  synchronous, active-low reset
commit_valid  in  1  instruction in WB is committing this cycle
commit_pc  in  32  PC of the committing instruction
commit_bd  in  1  committing instruction sits in a branch delay slot
exc_vec  in  7  {adel_if, ri, ov, sys, bp, adel, ades}, per-instruction exception flags
dm_addr  in  32  faulting data address (adel/ades)
eret  in  1  committing instruction is ERET
mtc0_wen  in  1  committing instruction is MTC0
cp0_addr  in  8  {rd[4:0], sel[2:0]}
mtc0_wdata  in  32  MTC0 data
mfc0_rdata  out  32  combinational read of cp0_addr
ext_int  in  HW_INT_NUM  level-sensitive external interrupts
flush  out  1  cancel the pipeline and redirect fetch
flush_pc  out  32  redirect target
int_pending  out  1  an enabled interrupt is pending
status_o, cause_o, epc_o  out  32 each  register views

Behaviour:
- Reset values:
  - Status = 32'h0040_0000 (BEV=1, IM=0, EXL=0, IE=0).
  - Cause, EPC, BadVAddr, Count, Compare = 0.
  - Prescaler = 0.
  - flush = 0.
- Interrupt sampling: ext_int is registered every cycle into Cause.IP[2+HW_INT_NUM-1:2]. Unused IP bits read 0.
- Timer IP: Cause.IP[TIMER_IP] reads as the registered line value OR TI.
- int_pending = Status.IE & ~Status.EXL & |(Cause.IP[7:0] & Status.IM[7:0]). Combinational from registers.
- take = commit_valid & (int_pending | |exc_vec). Only a committing instruction can take a trap; a bubble never traps.
- Priority, highest first: interrupt (ExcCode 0), adel_if (4), ri (10), ov (12), sys (8), bp (9), adel (4), ades (5).
- On take, at the clock edge:
  - Cause.ExcCode is set from the winning source.
  - Status.EXL is set to 1.
  - If EXL was 0 beforehand: EPC = commit_bd ? commit_pc-4 : commit_pc, and Cause.BD = commit_bd.
  - If EXL was already 1: EPC and BD are unchanged.
  - BadVAddr = commit_pc for adel_if; dm_addr for adel/ades; otherwise unchanged.
  - An MTC0 in the same commit is suppressed.
- ERET (commit_valid & eret & ~take): clears EXL at the edge. flush=1 and flush_pc=EPC in the same cycle, with EPC read before any same-cycle write.
- flush and flush_pc are combinational in the commit cycle:
  - On take: flush=1, flush_pc=EXC_VECTOR.
  - On ERET: as above.
  - Otherwise flush=0 and flush_pc=EPC.
- MTC0 (commit_valid & mtc0_wen & ~take) writable fields:
  - Status: IM[15:8], EXL[1], IE[0]. Other bits hold.
  - Cause: IP[9:8] only (software interrupts).
  - EPC, Count, Compare: full 32 bits.
  - BadVAddr and other addresses: writes ignored.
- Count prescaler:
  - Counter 0..COUNT_DIV-1. Count increments (wrapping 32'hFFFF_FFFF -> 0) when the prescaler equals COUNT_DIV-1; the prescaler then returns to 0.
  - MTC0 to Count writes the value and clears the prescaler; the write wins over an increment in that cycle.
- Timer interrupt (TI):
  - TI is set in the cycle after Count becomes equal to Compare.
  - MTC0 to Compare clears TI; the clear wins over a same-cycle set.
  - TI is held until cleared.
- mfc0_rdata returns 0 for unimplemented addresses. Cause bit 30 reads as TI.
- Reset during any activity returns every register to its reset value on the next edge. There is no pending state across reset.

Decomposition:
- Shared package cp0_pkg holds:
  - the ExcCode constants;
  - the CP0 address constants (8/9/11/12/13/14, sel 0);
  - the Status/Cause bit-position localparams.
- One sub-module, cp0_timer, contains the prescaler, Count, Compare and TI.

Test Plan:
1. Syscall at commit_pc=0xBFC0_0100, bd=0 -> flush=1, flush_pc=0xBFC0_0380; next cycle EPC=0xBFC0_0100, ExcCode=8, EXL=1.
2. adel at pc=0x8000_0010 with bd=1, dm_addr=0x8000_0003 -> EPC=0x8000_000C, Cause.BD=1, BadVAddr=0x8000_0003, ExcCode=4.
3. ri and ov set together, EXL already 1 -> ExcCode=10, EPC unchanged, flush_pc=0xBFC0_0380.
4. COUNT_DIV=2, MTC0 Compare=5, MTC0 Count=0, Status.IM[7]=1, IE=1 -> TI sets ~10 cycles later; next commit traps with ExcCode=0; MTC0 Compare clears TI.
5. ext_int[1]=1, IM[3]=1, IE=1, EXL=0, no commit for 4 cycles -> int_pending=1, no flush; first commit_valid traps, and EPC is that instruction's PC.
6. ERET with EPC=0xBFC0_0200 and MTC0 EPC in the same cycle -> flush_pc=0xBFC0_0200, EXL=0 next cycle.
